mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory port of the CPU between the fetch stage (I-port) and the load/store stage (D-port). It accepts one request at a time, drives the memory-side request/response handshake, and routes the response back to the owning requester. A requester stalls for as long as its request is pending without a grant. Data accesses have priority, with a bounded-starvation guard for fetch.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_age.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified I/D memory port arbiter.
package mem_arb_pkg;

  // Transaction phase of the shared memory port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Data accesses win unless only fetch is asking, or fetch has been starved.
  // Only meaningful when at least one of the requests is high.
  function automatic arb_owner_e arb_pick(input logic i_req,
                                          input logic d_req,
                                          input logic starved);
    arb_owner_e owner;
    if (d_req && !(i_req && starved)) begin
      owner = OWN_D;
    end else begin
      owner = OWN_I;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arb_age.sv
// Saturating count of consecutive data grants made while a fetch is waiting.
// 'starved' tells the arbiter that fetch must win the next contested slot.
module mem_arb_age
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_grant_while_i,
  input  logic i_grant,
  output logic starved
);

  localparam int unsigned   CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a fetch grant clears, a contested data grant adds one up to the cap.
  always_comb begin
    cnt_d = cnt_q;
    if (i_grant) begin
      cnt_d = {CW{1'b0}};
    end else if (d_grant_while_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch (I) and
// load/store (D). One transaction in flight at a time; D has priority with a
// bounded-starvation guard for I. All outputs come straight from flops.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  // fetch port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // memory side
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam int unsigned BW = DW / 8;

  arb_state_e      state_q,    state_d;
  arb_owner_e      owner_q,    owner_d;
  logic            i_gnt_q,    i_gnt_d;
  logic            d_gnt_q,    d_gnt_d;
  logic            i_rvalid_q, i_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   i_rdata_q,  i_rdata_d;
  logic [DW-1:0]   d_rdata_q,  d_rdata_d;
  logic            m_valid_q,  m_valid_d;
  logic            m_we_q,     m_we_d;
  logic [AW-1:0]   m_addr_q,   m_addr_d;
  logic [DW-1:0]   m_wdata_q,  m_wdata_d;
  logic [BW-1:0]   m_be_q,     m_be_d;

  logic            starved_s;
  arb_owner_e      pick_s;
  logic            d_grant_while_i_s;
  logic            i_grant_s;

  mem_arb_age #(
    .STARVE_MAX (STARVE_MAX)
  ) u_age (
    .clk             (clk),
    .reset           (reset),
    .d_grant_while_i (d_grant_while_i_s),
    .i_grant         (i_grant_s),
    .starved         (starved_s)
  );

  assign pick_s = arb_pick(i_req, d_req, starved_s);

  // Next-state and registered-output logic: arbitrate in IDLE, hold the
  // request in ISSUE until accepted, route the single response in WAIT.
  // Responses seen in IDLE or ISSUE are stale or illegal and are dropped.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    i_gnt_d           = 1'b0;
    d_gnt_d           = 1'b0;
    i_rvalid_d        = 1'b0;
    d_rvalid_d        = 1'b0;
    i_rdata_d         = {DW{1'b0}};
    d_rdata_d         = {DW{1'b0}};
    m_valid_d         = m_valid_q;
    m_we_d            = m_we_q;
    m_addr_d          = m_addr_q;
    m_wdata_d         = m_wdata_q;
    m_be_d            = m_be_q;
    d_grant_while_i_s = 1'b0;
    i_grant_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d   = ISSUE;
          owner_d   = pick_s;
          m_valid_d = 1'b1;
          if (pick_s == OWN_D) begin
            d_gnt_d           = 1'b1;
            m_we_d            = d_we;
            m_addr_d          = d_addr;
            m_wdata_d         = d_wdata;
            m_be_d            = d_be;
            d_grant_while_i_s = i_req;
          end else begin
            i_gnt_d   = 1'b1;
            i_grant_s = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = {DW{1'b0}};
            m_be_d    = {BW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (m_ready) begin
          state_d   = WAIT;
          m_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b1;
        end
      end

      WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            // a store completion carries no data
            d_rdata_d  = m_we_q ? {DW{1'b0}} : m_rdata;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end
        end else begin
          state_d = WAIT;
        end
      end

      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= {DW{1'b0}};
      d_rdata_q  <= {DW{1'b0}};
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= {AW{1'b0}};
      m_wdata_q  <= {DW{1'b0}};
      m_be_q     <= {BW{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      m_valid_q  <= m_valid_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
    end
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_valid  = m_valid_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level model of requesters
// and the arbitration rule.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned BW         = DW / 8;
  localparam int unsigned STARVE_MAX = 4;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_valid;
  logic          m_ready;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: outstanding requests, starvation age, grant history
  bit            pend_i;
  bit            pend_d;
  logic [AW-1:0] mi_addr;
  logic          md_we;
  logic [AW-1:0] md_addr;
  logic [DW-1:0] md_wdata;
  logic [BW-1:0] md_be;
  int            starve;
  bit            grant_log[$];

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".i_gnt"},    i_gnt,    64'd0);
    chk({tag, ".d_gnt"},    d_gnt,    64'd0);
    chk({tag, ".i_rvalid"}, i_rvalid, 64'd0);
    chk({tag, ".d_rvalid"}, d_rvalid, 64'd0);
    chk({tag, ".i_rdata"},  i_rdata,  64'd0);
    chk({tag, ".d_rdata"},  d_rdata,  64'd0);
    chk({tag, ".m_valid"},  m_valid,  64'd0);
    chk({tag, ".m_we"},     m_we,     64'd0);
    chk({tag, ".m_addr"},   m_addr,   64'd0);
    chk({tag, ".m_wdata"},  m_wdata,  64'd0);
    chk({tag, ".m_be"},     m_be,     64'd0);
    chk({tag, ".busy"},     busy,     64'd0);
  endtask

  task automatic raise_i(input logic [AW-1:0] a);
    pend_i = 1'b1; mi_addr = a;
    i_req = 1'b1; i_addr = a;
  endtask

  task automatic raise_d(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    pend_d = 1'b1; md_we = we; md_addr = a; md_wdata = wd; md_be = be;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
  endtask

  // a served requester drops its request and scribbles on its fields
  task automatic drop_winner(input bit win_d);
    if (win_d) begin
      pend_d = 1'b0; d_req = 1'b0;
      d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; d_be = BW'($urandom);
    end else begin
      pend_i = 1'b0; i_req = 1'b0; i_addr = $urandom;
    end
  endtask

  // One full transaction starting with requests visible in IDLE.
  // rdly: cycles of m_ready low; vdly: cycles between accept and response;
  // early_rv: also pulse m_rvalid together with m_ready (must be ignored).
  task automatic do_txn(input int rdly, input int vdly, input bit early_rv, input logic [DW-1:0] rd);
    bit            win_d;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] exp_data;
    if (pend_i && pend_d) win_d = (starve < STARVE_MAX);
    else                  win_d = pend_d;
    ea  = win_d ? md_addr : mi_addr;
    ewe = win_d ? md_we : 1'b0;
    if (win_d && pend_i) begin
      if (starve < STARVE_MAX) starve++;
    end else if (!win_d) begin
      starve = 0;
    end
    grant_log.push_back(win_d);

    step();
    chk("grant.i_gnt",   i_gnt,   !win_d);
    chk("grant.d_gnt",   d_gnt,   win_d);
    chk("grant.m_valid", m_valid, 1'b1);
    chk("grant.m_addr",  m_addr,  ea);
    chk("grant.m_we",    m_we,    ewe);
    if (win_d) begin
      chk("grant.m_wdata", m_wdata, md_wdata);
      chk("grant.m_be",    m_be,    md_be);
    end
    chk("grant.busy",   busy, 1'b1);
    chk("grant.rvalid", {i_rvalid, d_rvalid}, 2'b00);

    for (int k = 0; k < rdly; k++) begin
      m_ready = 1'b0;
      step();
      if (k == 0) drop_winner(win_d);
      chk("bp.m_valid", m_valid, 1'b1);
      chk("bp.m_addr",  m_addr,  ea);
      chk("bp.m_we",    m_we,    ewe);
      if (win_d) begin
        chk("bp.m_wdata", m_wdata, md_wdata);
        chk("bp.m_be",    m_be,    md_be);
      end
      chk("bp.gnt",  {i_gnt, d_gnt}, 2'b00);
      chk("bp.busy", busy, 1'b1);
    end

    m_ready = 1'b1; m_rvalid = early_rv; m_rdata = $urandom;
    step();
    m_ready = 1'b0; m_rvalid = 1'b0;
    if (rdly == 0) drop_winner(win_d);
    chk("acc.m_valid", m_valid, 1'b0);
    chk("acc.busy",    busy, 1'b1);
    chk("acc.gnt",     {i_gnt, d_gnt}, 2'b00);
    chk("acc.rvalid",  {i_rvalid, d_rvalid}, 2'b00);

    for (int k = 0; k < vdly; k++) begin
      step();
      chk("wait.rvalid", {i_rvalid, d_rvalid}, 2'b00);
      chk("wait.busy",   busy, 1'b1);
    end

    m_rvalid = 1'b1; m_rdata = rd;
    step();
    m_rvalid = 1'b0; m_rdata = $urandom;
    exp_data = (win_d && ewe) ? {DW{1'b0}} : rd;
    chk("resp.i_rvalid", i_rvalid, !win_d);
    chk("resp.d_rvalid", d_rvalid, win_d);
    if (win_d) begin
      chk("resp.d_rdata", d_rdata, exp_data);
      chk("resp.i_rdata", i_rdata, 64'd0);
    end else begin
      chk("resp.i_rdata", i_rdata, exp_data);
      chk("resp.d_rdata", d_rdata, 64'd0);
    end
    chk("resp.busy",    busy,    1'b0);
    chk("resp.m_valid", m_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    pend_i = 1'b0; pend_d = 1'b0; starve = 0;
    mi_addr = '0; md_we = 1'b0; md_addr = '0; md_wdata = '0; md_be = '0;

    // reset state
    step(); step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    chk_zero("post_reset");

    // single fetch, immediate memory
    raise_i(32'h0000_0100);
    do_txn(0, 0, 1'b0, 32'h0050_0093);

    // simultaneous fetch and load: load first, fetch in the next IDLE
    raise_i(32'h0000_3000);
    raise_d(1'b0, 32'h0000_2000, 32'h1111_2222, 4'hF);
    do_txn(0, 0, 1'b0, $urandom);
    chk("simul.first_is_d", grant_log[$], 1'b1);
    do_txn(0, 2, 1'b0, $urandom);
    chk("simul.second_is_i", grant_log[$], 1'b0);

    // store: exact fields out, zero data back
    raise_d(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
    do_txn(0, 1, 1'b0, 32'hCAFE_F00D);

    // backpressure for 5 cycles
    raise_d(1'b0, 32'h0000_8888, 32'h0, 4'h0);
    do_txn(5, 0, 1'b0, $urandom);

    // response coinciding with acceptance must be ignored
    raise_i(32'h0000_0200);
    do_txn(0, 1, 1'b1, $urandom);

    // starvation with both requesters held: D D D D I D D D
    grant_log.delete();
    raise_i($urandom);
    raise_d(1'b0, $urandom, $urandom, BW'($urandom));
    for (int t = 0; t < 8; t++) begin
      do_txn(0, 0, 1'b0, $urandom);
      if (!pend_i) raise_i($urandom);
      if (!pend_d) raise_d(1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom));
    end
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("starve.order%0d", t), grant_log[t], (t == 4) ? 1'b0 : 1'b1);
    end

    // reset during WAIT, with the age counter at its cap
    step();
    chk("rstw.d_gnt", d_gnt, 1'b1);
    chk("rstw.i_gnt", i_gnt, 1'b0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("rstw.busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk_zero("rst_async");
    step();
    reset = 1'b0;
    drop_winner(1'b0);
    drop_winner(1'b1);
    starve = 0;
    step();
    chk_zero("rst_idle");
    m_rvalid = 1'b1; m_rdata = $urandom;
    step();
    m_rvalid = 1'b0;
    chk_zero("rst_stale");
    step();
    chk_zero("rst_stale2");
    // re-issue both: age was cleared, so data must win
    raise_i($urandom);
    raise_d(1'b0, $urandom, $urandom, BW'($urandom));
    do_txn(0, 0, 1'b0, $urandom);
    chk("rst_recover.d_first", grant_log[$], 1'b1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if (!pend_i && ($urandom_range(0, 1) == 1)) raise_i($urandom);
      if (!pend_d && ($urandom_range(0, 1) == 1))
        raise_d(1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom));
      if (!pend_i && !pend_d) begin
        step();
        chk("idle.busy",    busy,    1'b0);
        chk("idle.m_valid", m_valid, 1'b0);
        chk("idle.gnt",     {i_gnt, d_gnt}, 2'b00);
      end else begin
        do_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
